seq_arith_unit: RTL and testbench
=================================

Name: seq_arith_unit

Overview:
Multi-cycle signed arithmetic unit for the 8-bit four-function calculator. It takes two signed 8-bit operands and an opcode, and computes add, subtract, multiply or divide. Multiply uses iterative shift-add; divide uses restoring shift-subtract. It sits directly upstream of the output unit and produces the 16-bit signed Result that the output unit displays. Its Done pulse is the load strobe the output unit uses to capture Result.

Parameters:
N, 8, operand width in bits (two's complement)
RW, 16, result width in bits (2*N); Result is always sign-extended to RW

Ports:
CLK  input  1  system clock; all state updates on rising edge
CLR_N  input  1  asynchronous active-low reset
Start  input  1  request; sampled only in IDLE
Op  input  2  00 add, 01 subtract (A-B), 10 multiply, 11 divide (A/B)
A  input  N  signed operand A
B  input  N  signed operand B
Result  output  RW  signed result register; holds its value until the next completion
Done  output  1  one-cycle pulse in the cycle Result becomes valid
Busy  output  1  high whenever the state is not IDLE
DivZero  output  1  sticky error flag: last accepted divide had B=0

Behaviour:
- Reset (CLR_N low, asynchronous): state IDLE; Result=0, Done=0, Busy=0, DivZero=0; counter=0; operand registers=0. Reset asserted mid-operation aborts the operation; no Done is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - Start=1 latches A, B and Op, clears DivZero, and moves to CALC.
  - Start=0 keeps the state in IDLE.
- Start while Busy=1: ignored. No queuing; operands are not re-latched.
- CALC, add/sub:
  - Sign-extend both operands to RW, then add or subtract.
  - Load Result, go to DONE after 1 cycle.
- CALC, multiply:
  - Take magnitudes |A| and |B| (N-bit unsigned; |-128|=128).
  - Run N iterations of shift-add; counter counts 0..N-1.
  - On the last iteration, negate the product if sign(A) xor sign(B), load Result, go to DONE.
- CALC, divide with B=0:
  - Result=0, DivZero=1, go to DONE after 1 cycle. No iteration.
- CALC, divide with B nonzero:
  - Run N iterations of restoring division on magnitudes.
  - The quotient truncates toward zero; negate it if the signs differ.
  - Sign-extend into Result. The remainder is discarded.
- DONE: Done=1 for exactly this cycle, then return to IDLE unconditionally.
- Latency, with Start sampled at edge t:
  - Add, sub and divide-by-zero: Done high in cycle t+2.
  - Multiply and divide: Done high in cycle t+N+1 (t+9 for N=8).
- Throughput: a new Start is accepted in the cycle after DONE (IDLE).
- Width rules:
  - All RW-bit results are exact; no overflow is possible for N=8.
  - Extremes: -128-127=-255; -128*-128=16384; -128/-1=128.
- Result changes only on entry to DONE (or on reset).
- DivZero persists until the next accepted Start.
- Op/A/B changes after Start is accepted have no effect on the current operation.

Decomposition:
- Package calc_pkg:
  - op_t enum (OP_ADD, OP_SUB, OP_MUL, OP_DIV)
  - state_t enum (IDLE, CALC, DONE)
  - localparams for N, RW and the counter width ($clog2(N))
- One natural sub-module, abs_nbit (parameter N): combinational two's-complement magnitude plus sign bit. It is instantiated twice, for A and for B.
- The FSM, counter and shift datapath stay in seq_arith_unit.

Test Plan:
1. Reset, then Op=00, A=100, B=27, Start for 1 cycle -> Done at t+2; Result=16'd127; Busy high for exactly 2 cycles.
2. Op=01, A=-128, B=127 -> Result=16'hFF01 (-255); DivZero=0.
3. Op=10: A=-128, B=-128 -> Result=16'h4000 (16384), Done at t+9. A=-7, B=13 -> Result=16'hFFA5 (-91).
4. Op=11: A=-100, B=7 -> Result=16'hFFF2 (-14). A=-128, B=-1 -> Result=16'h0080. A=5, B=0 -> Result=0, DivZero=1, Done at t+2. A following add clears DivZero.
5. Start pulsed again during a multiply at t+4 with different operands -> ignored; the first result is unchanged; exactly one Done.
6. CLR_N driven low mid-divide at t+5 -> all outputs 0 immediately (asynchronously); no Done. After release, a new add completes normally.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared widths, opcode and state types for the sequential arithmetic unit.
package calc_pkg;
    localparam int CALC_N  = 8;
    localparam int CALC_RW = 2 * CALC_N;
    localparam int CALC_CW = $clog2(CALC_N);
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/abs_nbit.sv
// abs_nbit: two's-complement magnitude and sign; the most negative value maps to 2^(N-1) unsigned.
module abs_nbit #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_x,
    output logic [N-1:0] o_mag,
    output logic         o_sign
);
    assign o_sign = i_x[N-1];
    assign o_mag  = o_sign ? -i_x : i_x;
endmodule

// File: rtl/seq_arith_unit.sv
// seq_arith_unit: multi-cycle signed add/sub/mul/div on N-bit operands, RW-bit sign-extended result.
module seq_arith_unit
    import calc_pkg::*;
(
    input  logic                CLK,
    input  logic                CLR_N,
    input  logic                Start,
    input  logic [1:0]          Op,
    input  logic [CALC_N-1:0]   A,
    input  logic [CALC_N-1:0]   B,
    output logic [CALC_RW-1:0]  Result,
    output logic                Done,
    output logic                Busy,
    output logic                DivZero
);
    localparam int N  = CALC_N;
    localparam int RW = CALC_RW;
    localparam int CW = CALC_CW;

    state_t          r_state;
    op_t             r_op;
    logic [N-1:0]    r_a, r_b, r_q, r_rem;
    logic [CW-1:0]   r_cnt;
    logic [RW-1:0]   r_prod, r_res;
    logic            r_done, r_busy, r_dz;

    logic [N-1:0]    w_mag_a, w_mag_b, w_q_in, w_q_nx, w_rem_nx;
    logic            w_sa, w_sb, w_neg, w_last, w_dz, w_fin, w_ge;
    logic [N:0]      w_rem_sh, w_diff;
    logic [RW-1:0]   w_pp, w_quo, w_sum, w_res;

    abs_nbit #(.N(N)) u_abs_a (.i_x(r_a), .o_mag(w_mag_a), .o_sign(w_sa));
    abs_nbit #(.N(N)) u_abs_b (.i_x(r_b), .o_mag(w_mag_b), .o_sign(w_sb));

    assign w_neg  = w_sa ^ w_sb;
    assign w_last = r_cnt == CW'(N - 1);
    assign w_dz   = (r_op == OP_DIV) && (r_b == '0);
    assign w_fin  = (r_op == OP_ADD) || (r_op == OP_SUB) || w_dz || w_last;
    assign w_sum  = (r_op == OP_SUB) ? {{(RW-N){r_a[N-1]}}, r_a} - {{(RW-N){r_b[N-1]}}, r_b}
                                     : {{(RW-N){r_a[N-1]}}, r_a} + {{(RW-N){r_b[N-1]}}, r_b};
    assign w_pp   = r_prod + (w_mag_b[r_cnt] ? ({{(RW-N){1'b0}}, w_mag_a} << r_cnt) : '0);

    // Dividend magnitude is taken straight from the operand on the first iteration.
    assign w_q_in   = (r_cnt == '0) ? w_mag_a : r_q;
    assign w_rem_sh = {r_rem, w_q_in[N-1]};
    assign w_diff   = w_rem_sh - {1'b0, w_mag_b};
    assign w_ge     = !w_diff[N];
    assign w_q_nx   = {w_q_in[N-2:0], w_ge};
    assign w_rem_nx = w_ge ? w_diff[N-1:0] : w_rem_sh[N-1:0];
    assign w_quo    = {{(RW-N){1'b0}}, w_q_nx};

    assign w_res = (r_op == OP_MUL) ? (w_neg ? -w_pp : w_pp)
                 : (r_op == OP_DIV) ? (w_dz ? '0 : w_neg ? -w_quo : w_quo)
                 : w_sum;

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            r_state <= IDLE;
            r_op    <= OP_ADD;
            r_a     <= '0;
            r_b     <= '0;
            r_q     <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_prod  <= '0;
            r_res   <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (Start) begin
                    r_state <= CALC;
                    r_busy  <= 1'b1;
                    r_dz    <= 1'b0;
                    r_op    <= op_t'(Op);
                    r_a     <= A;
                    r_b     <= B;
                    r_cnt   <= '0;
                    r_prod  <= '0;
                    r_rem   <= '0;
                end
                CALC: begin
                    r_cnt  <= r_cnt + CW'(1);
                    r_prod <= w_pp;
                    r_q    <= w_q_nx;
                    r_rem  <= w_rem_nx;
                    if (w_fin) begin
                        r_state <= DONE;
                        r_res   <= w_res;
                        r_done  <= 1'b1;
                        r_dz    <= w_dz;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Result  = r_res;
    assign Done    = r_done;
    assign Busy    = r_busy;
    assign DivZero = r_dz;
endmodule

// File: tb/tb_seq_arith_unit.sv
// tb_seq_arith_unit: directed vectors with a queue scoreboard checked by an independent Done monitor.
module tb_seq_arith_unit;
    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [7:0]  a = 8'd0, b = 8'd0;
    logic [15:0] result;
    logic        done, busy, div_zero;

    typedef struct {
        logic [15:0] res;
        logic        dz;
        int          t0;
        int          lat;
        int          id;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    seq_arith_unit dut (
        .CLK(clk), .CLR_N(clr_n), .Start(start), .Op(op), .A(a), .B(b),
        .Result(result), .Done(done), .Busy(busy), .DivZero(div_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int id, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (vec %0d): got %h expected %h", name, id, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (clr_n && done) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got Done=1 with Result=%h, expected no Done", result);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", e.id, result, e.res);
                chk("divzero", e.id, 16'(div_zero), 16'(e.dz));
                chk("latency", e.id, 16'(cyc - e.t0), 16'(e.lat));
            end
        end
    end

    task automatic start_op(input bit push, input int id, input logic [1:0] o, input int av, input int bv,
                            input logic [15:0] res, input logic dz, input int lat);
        exp_t e;
        @(negedge clk);
        op = o;
        a = av[7:0];
        b = bv[7:0];
        start = 1'b1;
        e.res = res; e.dz = dz; e.t0 = cyc; e.lat = lat; e.id = id;
        if (push) q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        op = ~o;
        a = ~a;
        b = ~b;
    endtask

    task automatic drain(input int id);
        for (int i = 0; i < 30 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout (vec %0d): got %0d pending results, expected 0", id, q.size());
            q.delete();
        end
    endtask

    task automatic run(input int id, input logic [1:0] o, input int av, input int bv,
                       input logic [15:0] res, input logic dz, input int lat);
        start_op(1'b1, id, o, av, bv, res, dz, lat);
        drain(id);
    endtask

    initial begin
        int busy_cnt;
        #12;
        chk("reset_result", 0, result, 16'h0000);
        chk("reset_flags", 0, {13'd0, done, busy, div_zero}, 16'h0000);
        @(negedge clk);
        clr_n = 1'b1;

        // 1: add, with Busy width observed
        start_op(1'b1, 1, 2'b00, 100, 27, 16'd127, 1'b0, 2);
        busy_cnt = int'(busy);
        repeat (4) begin
            @(negedge clk);
            busy_cnt += int'(busy);
        end
        chk("busy_cycles", 1, 16'(busy_cnt), 16'd2);
        drain(1);

        run(2, 2'b01, -128, 127, 16'hFF01, 1'b0, 2);
        run(3, 2'b10, -128, -128, 16'h4000, 1'b0, 9);
        run(4, 2'b10, -7, 13, 16'hFFA5, 1'b0, 9);
        run(5, 2'b10, 127, 127, 16'h3F01, 1'b0, 9);
        run(6, 2'b11, -100, 7, 16'hFFF2, 1'b0, 9);
        run(7, 2'b11, -128, -1, 16'h0080, 1'b0, 9);
        run(8, 2'b11, 7, -2, 16'hFFFD, 1'b0, 9);
        run(9, 2'b11, 5, 0, 16'h0000, 1'b1, 2);
        repeat (3) @(negedge clk);
        chk("divzero_sticky", 9, 16'(div_zero), 16'd1);
        run(10, 2'b00, 3, 4, 16'd7, 1'b0, 2);

        // 5: second Start during a multiply must be ignored
        start_op(1'b1, 11, 2'b10, -7, 13, 16'hFFA5, 1'b0, 9);
        repeat (3) @(negedge clk);
        op = 2'b00; a = 8'd50; b = 8'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain(11);
        repeat (12) @(negedge clk);
        chk("held_result", 11, result, 16'hFFA5);

        // 6: asynchronous reset mid-divide
        start_op(1'b0, 12, 2'b11, -100, 7, 16'h0000, 1'b0, 9);
        repeat (4) @(negedge clk);
        chk("busy_before_abort", 12, 16'(busy), 16'd1);
        #2 clr_n = 1'b0;
        #1;
        chk("abort_result", 12, result, 16'h0000);
        chk("abort_flags", 12, {13'd0, done, busy, div_zero}, 16'h0000);
        @(negedge clk);
        clr_n = 1'b1;
        repeat (12) @(negedge clk);
        run(13, 2'b00, 10, -20, 16'hFFF6, 1'b0, 2);
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected bench end");
        $fatal(1, "watchdog");
    end
endmodule
